adder_stage2_driver: RTL and testbench

Initiator for the second-stage three-operand adder in the convolution datapath. Collects a serial stream of 8-bit partial sums in groups of three, presents each group to the adder stage over its `enable`/`done` handshake, captures the sum and forwards it downstream with valid/ready. Counts results per output frame and flags a hung adder via a timeout.

---
 rtl/adder_stage2_driver.sv | 153 +++++++++++++++
 tb/tb_adder_stage2_driver.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_stage2_driver.sv
// Initiator for the second-stage three-operand adder: gathers three partial sums,
// runs the enable/done handshake, and forwards the sum downstream with valid/ready.
module adder_stage2_driver #(
    parameter int GROUPS  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] add_in1,
    output logic [7:0] add_in2,
    output logic [7:0] add_in3,
    output logic       add_enable,
    input  logic [7:0] add_result,
    input  logic       add_done,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       frame_done,
    output logic       err
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int GC_W = $clog2(GROUPS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [GC_W-1:0] GC_LAST = GC_W'(GROUPS - 1);

    localparam logic [1:0] COLLECT   = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;
    localparam logic [1:0] OUTPUT    = 2'd3;

    logic [1:0]      state_r;
    logic [1:0]      slot_r;
    logic [7:0]      op1_r;
    logic [7:0]      op2_r;
    logic [7:0]      op3_r;
    logic            add_enable_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic [7:0]      out_data_r;
    logic            frame_done_r;
    logic            err_r;
    logic [TO_W-1:0] to_cnt_r;
    logic [GC_W-1:0] grp_cnt_r;
    logic            in_fire_s;
    logic            out_fire_s;

    assign in_fire_s  = in_valid && in_ready_r;
    assign out_fire_s = out_valid_r && out_ready;

    // Sequencer: collect three beats, run the adder handshake, then hold the result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= COLLECT;
            slot_r       <= 2'd0;
            op1_r        <= 8'h00;
            op2_r        <= 8'h00;
            op3_r        <= 8'h00;
            add_enable_r <= 1'b0;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            out_data_r   <= 8'h00;
            frame_done_r <= 1'b0;
            err_r        <= 1'b0;
            to_cnt_r     <= '0;
            grp_cnt_r    <= '0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                COLLECT: begin
                    if (in_fire_s) begin
                        case (slot_r)
                            2'd0:    op1_r <= in_data;
                            2'd1:    op2_r <= in_data;
                            default: op3_r <= in_data;
                        endcase
                        if (slot_r == 2'd2) begin
                            slot_r     <= 2'd0;
                            in_ready_r <= 1'b0;
                            to_cnt_r   <= '0;
                            // A done still high from the previous request must drain first.
                            if (!add_done) begin
                                add_enable_r <= 1'b1;
                                state_r      <= WAIT_DONE;
                            end else begin
                                state_r <= ISSUE;
                            end
                        end else begin
                            slot_r <= slot_r + 2'd1;
                        end
                    end
                end
                ISSUE: begin
                    if (!add_done) begin
                        add_enable_r <= 1'b1;
                        state_r      <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (add_done) begin
                        out_data_r   <= add_result;
                        add_enable_r <= 1'b0;
                        out_valid_r  <= 1'b1;
                        state_r      <= OUTPUT;
                    end else if (to_cnt_r == TO_LAST) begin
                        // Hung adder: emit a zero result so the frame still completes.
                        out_data_r   <= 8'h00;
                        err_r        <= 1'b1;
                        add_enable_r <= 1'b0;
                        out_valid_r  <= 1'b1;
                        state_r      <= OUTPUT;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                OUTPUT: begin
                    if (out_fire_s) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= COLLECT;
                        if (grp_cnt_r == GC_LAST) begin
                            grp_cnt_r    <= '0;
                            frame_done_r <= 1'b1;
                        end else begin
                            grp_cnt_r <= grp_cnt_r + GC_W'(1);
                        end
                    end
                end
                default: begin
                    state_r      <= COLLECT;
                    slot_r       <= 2'd0;
                    add_enable_r <= 1'b0;
                    in_ready_r   <= 1'b1;
                    out_valid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign add_in1    = op1_r;
    assign add_in2    = op2_r;
    assign add_in3    = op3_r;
    assign add_enable = add_enable_r;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign frame_done = frame_done_r;
    assign err        = err_r;

endmodule

// File: tb/tb_adder_stage2_driver.sv
// Directed, table-driven bench for adder_stage2_driver with a one-cycle model adder.
module tb_adder_stage2_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [7:0] add_in1, add_in2, add_in3;
    logic       add_enable;
    logic [7:0] add_result;
    logic       add_done;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b1;
    logic       frame_done;
    logic       err;

    logic       adder_on = 1'b1;
    logic       stale_force = 1'b0;
    logic       done_m = 1'b0;
    logic [7:0] res_m = 8'h00;

    int checks = 0;
    int errors = 0;
    int res_idx = 0;
    logic exp_err = 1'b0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] sum;
    } vec_t;
    vec_t vecs[6];

    adder_stage2_driver dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .add_in1(add_in1), .add_in2(add_in2), .add_in3(add_in3), .add_enable(add_enable),
        .add_result(add_result), .add_done(add_done), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    // Model adder: one-cycle latency, done follows enable by one edge.
    always @(posedge clk) begin
        done_m <= add_enable & adder_on;
        res_m  <= add_in1 + add_in2 + add_in3;
    end
    assign add_done   = done_m | stale_force;
    assign add_result = res_m;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_add_enable"}, add_enable, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_ops"}, {add_in1, add_in2, add_in3}, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_err = 1'b0;
        res_idx = 0;
    endtask

    task automatic send_beat(input logic [7:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data = d;
        while (in_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("beat_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic expect_frame(input string tag);
        check({tag, "_frame_done"}, frame_done, (res_idx == 8) ? 1 : 0);
        res_idx = (res_idx + 1) % 9;
    endtask

    // Zero-wait adder, always-ready sink: fixed cycle-by-cycle timing.
    task automatic run_group(input logic [7:0] a, b, c, sum, input string tag);
        send_beat(a);
        send_beat(b);
        send_beat(c);
        check({tag, "_enable_E0"}, add_enable, 1);
        check({tag, "_in_ready_E0"}, in_ready, 0);
        check({tag, "_ops"}, {add_in1, add_in2, add_in3}, {8'h00, a, b, c});
        step();
        check({tag, "_valid_E1"}, out_valid, 0);
        step();
        check({tag, "_valid_E2"}, out_valid, 1);
        check({tag, "_enable_E2"}, add_enable, 0);
        check({tag, "_sum"}, out_data, sum);
        check({tag, "_err"}, err, exp_err);
        step();
        check({tag, "_valid_E3"}, out_valid, 0);
        check({tag, "_in_ready_E3"}, in_ready, 1);
        expect_frame(tag);
    endtask

    initial begin
        int n;
        vecs[0] = '{8'd10,  8'd20,  8'd30,  8'd60};
        vecs[1] = '{8'd200, 8'd100, 8'd50,  8'd94};
        vecs[2] = '{8'd255, 8'd1,   8'd0,   8'd0};
        vecs[3] = '{8'd0,   8'd0,   8'd0,   8'd0};
        vecs[4] = '{8'd128, 8'd128, 8'd255, 8'd255};
        vecs[5] = '{8'd7,   8'd8,   8'd9,   8'd24};

        step();
        step();
        pulse_reset();
        check_idle("reset");

        for (int i = 0; i < 6; i++) begin
            run_group(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sum, $sformatf("vec%0d", i));
        end

        // Frame counting from a clean reset: nine results, then wrap.
        pulse_reset();
        for (int g = 0; g < 10; g++) begin
            run_group(8'd1, 8'd1, 8'd1, 8'd3, $sformatf("frame_g%0d", g));
        end

        // Hung adder: timeout after 15 wait cycles, err sticks.
        adder_on = 1'b0;
        send_beat(8'd11);
        send_beat(8'd22);
        send_beat(8'd33);
        check("to_enable", add_enable, 1);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("to_cycles", n, 15);
        check("to_data", out_data, 0);
        check("to_err", err, 1);
        check("to_enable_drop", add_enable, 0);
        exp_err = 1'b1;
        adder_on = 1'b1;
        step();
        expect_frame("to");
        run_group(8'd3, 8'd4, 8'd5, 8'd12, "after_to");

        // Backpressure: result held, no input accepted.
        out_ready = 1'b0;
        send_beat(8'd50);
        send_beat(8'd60);
        send_beat(8'd70);
        step();
        step();
        check("bp_valid", out_valid, 1);
        in_valid = 1'b1;
        in_data = 8'hAA;
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_data", out_data, 180);
            check("bp_in_ready", in_ready, 0);
            check("bp_ops", {add_in1, add_in2, add_in3}, {8'd50, 8'd60, 8'd70});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release", out_valid, 0);
        expect_frame("bp");

        // Stale done: request held off until done drops.
        stale_force = 1'b1;
        send_beat(8'd1);
        send_beat(8'd2);
        send_beat(8'd4);
        check("stale_enable0", add_enable, 0);
        step();
        step();
        check("stale_enable2", add_enable, 0);
        check("stale_in_ready", in_ready, 0);
        stale_force = 1'b0;
        step();
        check("stale_issue", add_enable, 1);
        step();
        step();
        check("stale_valid", out_valid, 1);
        check("stale_sum", out_data, 7);
        step();
        expect_frame("stale");

        // Reset in WAIT_DONE (also clears the sticky err).
        adder_on = 1'b0;
        send_beat(8'd9);
        send_beat(8'd9);
        send_beat(8'd9);
        step();
        step();
        check("rstw_enable", add_enable, 1);
        pulse_reset();
        adder_on = 1'b1;
        check_idle("rst_wait");

        // Reset after two beats discards the partial group.
        send_beat(8'd1);
        send_beat(8'd2);
        pulse_reset();
        check_idle("rst_partial");
        run_group(8'd5, 8'd6, 8'd7, 8'd18, "fresh");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
